id_ex_reg: RTL

//   Decode-to-execute pipeline register of the 5-stage MIPS core. Captures D-stage

---
 rtl/id_ex_reg_pkg.sv | 9 +
 rtl/id_ex_reg_pipe_reg.sv | 30 +++
 rtl/id_ex_reg.sv | 73 +++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline constants for the MIPS pipeline registers.
// These are the bubble/reset values and the Tnew field width.
package id_ex_reg_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam int          TNEW_W_DEF   = 2;

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Single pipeline field: an async-reset flop with hold enable and a synchronous clear.
// The clear loads RST_VAL, so a bubble looks exactly like the post-reset state.
module id_ex_reg_pipe_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // clr outranks en, and d_i is never sampled while clr is high, so X inputs cannot leak
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RST_VAL;
    end else if (clr_i) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: holds D-stage results for the E stage, with freeze (en=0)
// and bubble insertion (clr=1). Tnew is aged by one stage as it is captured.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter int          TNEW_W   = TNEW_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [31:0]       d_instr,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_rs_data,
  input  logic [31:0]       d_rt_data,
  input  logic [31:0]       d_e32,
  input  logic [4:0]        d_a3,
  input  logic [TNEW_W-1:0] d_tnew,
  output logic [31:0]       e_instr,
  output logic [31:0]       e_pc,
  output logic [31:0]       e_rs_data,
  output logic [31:0]       e_rt_data,
  output logic [31:0]       e_e32,
  output logic [4:0]        e_a3,
  output logic [TNEW_W-1:0] e_tnew,
  output logic              e_valid
);

  logic [TNEW_W-1:0] tnew_d;

  // Saturating decrement: a result already ready in D stays ready in E
  always_comb begin
    tnew_d = '0;
    if (d_tnew != '0) begin
      tnew_d = d_tnew - TNEW_W'(1);
    end
  end

  id_ex_reg_pipe_reg #(.WIDTH(32), .RST_VAL(NOP_INSTR)) u_instr (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_instr), .q_o(e_instr)
  );

  id_ex_reg_pipe_reg #(.WIDTH(32), .RST_VAL(PC_RESET)) u_pc (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_pc), .q_o(e_pc)
  );

  id_ex_reg_pipe_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_rs_data (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_rs_data), .q_o(e_rs_data)
  );

  id_ex_reg_pipe_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_rt_data (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_rt_data), .q_o(e_rt_data)
  );

  id_ex_reg_pipe_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_e32 (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_e32), .q_o(e_e32)
  );

  id_ex_reg_pipe_reg #(.WIDTH(5), .RST_VAL(5'd0)) u_a3 (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(d_a3), .q_o(e_a3)
  );

  id_ex_reg_pipe_reg #(.WIDTH(TNEW_W), .RST_VAL('0)) u_tnew (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(tnew_d), .q_o(e_tnew)
  );

  // A captured slot is always a real instruction; bubbles come only from reset/clr
  id_ex_reg_pipe_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_valid (
    .clk_i(clk), .rst_i(reset), .en_i(en), .clr_i(clr), .d_i(1'b1), .q_o(e_valid)
  );

endmodule
